// File: rtl/wrr_sched.sv
// wrr_sched: weighted round-robin scheduler over NQ packet queues.
// One grant per packet; credits per queue reload from weights each round.
// Optional build macro WRR_STRICT_TOP_EN: queue NQ-1 becomes strict priority.
module wrr_sched #(
  parameter int unsigned NQ      = 8,
  parameter int unsigned QID_BIT = 3,
  parameter int unsigned WGT_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NQ-1:0]         q_vld,
  input  logic [NQ*WGT_BIT-1:0] weights,
  output logic                  grant_vld,
  output logic [QID_BIT-1:0]    grant_id,
  input  logic                  grant_rdy,
  input  logic                  pkt_done,
  output logic                  busy,
  output logic                  round_start
);

`ifdef WRR_STRICT_TOP_EN
  localparam bit STRICT_TOP = 1'b1;
`else
  localparam bit STRICT_TOP = 1'b0;
`endif

  localparam logic [QID_BIT-1:0] TOP_ID = QID_BIT'(NQ - 1);

  typedef enum logic [1:0] {IDLE, RELOAD, OFFER, BUSY} state_t;

  state_t               state_q, state_d;
  logic [WGT_BIT-1:0]   credit_q [NQ];
  logic [WGT_BIT-1:0]   credit_d [NQ];
  logic [QID_BIT-1:0]   ptr_q, ptr_d;
  logic [QID_BIT-1:0]   grant_id_q, grant_id_d;
  logic                 grant_vld_q, grant_vld_d;
  logic                 busy_q, busy_d;
  logic                 round_start_q, round_start_d;
  logic                 strict_q, strict_d;

  logic [NQ-1:0]        wrr_req;
  logic [NQ-1:0]        eligible;
  logic                 found;
  logic [QID_BIT-1:0]   pick;
  logic [QID_BIT-1:0]   idx;

  // WRR request and eligibility masks; the strict queue never takes part in WRR
  always_comb begin
    wrr_req = q_vld;
    if (STRICT_TOP) wrr_req[NQ-1] = 1'b0;
    for (int unsigned i = 0; i < NQ; i++)
      eligible[i] = wrr_req[i] && (credit_q[i] != '0);
  end

  // First eligible queue at or after ptr, wrapping modulo NQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      idx = ptr_q + QID_BIT'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state logic for arbitration, credit bookkeeping and handshake
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    grant_vld_d   = grant_vld_q;
    busy_d        = busy_q;
    round_start_d = 1'b0;
    strict_d      = strict_q;
    unique case (state_q)
      IDLE: begin
        if (STRICT_TOP && q_vld[NQ-1]) begin
          grant_id_d  = TOP_ID;
          strict_d    = 1'b1;
          grant_vld_d = 1'b1;
          state_d     = OFFER;
        end else if (found) begin
          grant_id_d  = pick;
          strict_d    = 1'b0;
          grant_vld_d = 1'b1;
          state_d     = OFFER;
        end else if (wrr_req != '0) begin
          round_start_d = 1'b1;
          state_d       = RELOAD;
        end
      end
      RELOAD: begin
        for (int unsigned i = 0; i < NQ; i++)
          credit_d[i] = weights[i*WGT_BIT +: WGT_BIT];
        state_d = IDLE;
      end
      OFFER: begin
        if (grant_rdy) begin
          grant_vld_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = BUSY;
          if (!strict_q)
            credit_d[grant_id_q] = credit_q[grant_id_q] - WGT_BIT'(1);
        end
      end
      BUSY: begin
        if (pkt_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          // stay on a queue that still has credit, otherwise move past it
          if (!strict_q)
            ptr_d = (credit_q[grant_id_q] != '0) ? grant_id_q
                                                 : grant_id_q + QID_BIT'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      for (int unsigned i = 0; i < NQ; i++) credit_q[i] <= '0;
      ptr_q         <= '0;
      grant_id_q    <= '0;
      grant_vld_q   <= 1'b0;
      busy_q        <= 1'b0;
      round_start_q <= 1'b0;
      strict_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      grant_vld_q   <= grant_vld_d;
      busy_q        <= busy_d;
      round_start_q <= round_start_d;
      strict_q      <= strict_d;
    end
  end

  assign grant_vld   = grant_vld_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign round_start = round_start_q;

endmodule

// File: tb/tb_wrr_sched.sv
// tb_wrr_sched: vector table, directed corner sequences and a randomized
// run against a queue-level round-robin credit model.
module tb_wrr_sched;
  localparam int NQ = 8;
  localparam int WB = 4;

`ifdef WRR_STRICT_TOP_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  q_vld = '0;
  logic [31:0] weights = '0;
  logic        grant_vld;
  logic [2:0]  grant_id;
  logic        grant_rdy = 1'b0;
  logic        pkt_done = 1'b0;
  logic        busy;
  logic        round_start;

  wrr_sched #(.NQ(8), .QID_BIT(3), .WGT_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .q_vld(q_vld), .weights(weights),
    .grant_vld(grant_vld), .grant_id(grant_id), .grant_rdy(grant_rdy),
    .pkt_done(pkt_done), .busy(busy), .round_start(round_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rs_total = 0;
  int rs_base = 0;

  // count round_start pulses
  always @(posedge clk) if (round_start === 1'b1) rs_total <= rs_total + 1;

  // reference model state
  int m_cred [NQ];
  int m_ptr;
  int m_reloads;

  typedef struct packed {
    logic [7:0]  q;
    logic [31:0] w;
    logic [3:0]  n;
    logic [39:0] seq;   // grant k in nibble k
    logic [3:0]  rs;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NQ; i++) m_cred[i] = 0;
    m_ptr = 0;
    m_reloads = 0;
  endfunction

  // next grant per the scheduling rules, reloading credits when needed
  function automatic int m_pick();
    int idx;
    if (STRICT && q_vld[NQ-1]) return NQ - 1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < NQ; k++) begin
        idx = (m_ptr + k) % NQ;
        if (!(STRICT && idx == NQ - 1) && q_vld[idx] && m_cred[idx] > 0) return idx;
      end
      if (pass == 0) begin
        for (int i = 0; i < NQ; i++) m_cred[i] = int'(weights[i*WB +: WB]);
        m_reloads++;
      end
    end
    return -1;
  endfunction

  function automatic void m_accept(input int id);
    if (STRICT && id == NQ - 1) return;
    m_cred[id] = m_cred[id] - 1;
    m_ptr = (m_cred[id] > 0) ? id : (id + 1) % NQ;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    grant_rdy = 1'b0;
    pkt_done = 1'b0;
    q_vld = '0;
    repeat (2) @(negedge clk);
    chk("reset grant_vld", grant_vld, 0);
    chk("reset grant_id", grant_id, 0);
    chk("reset busy", busy, 0);
    chk("reset round_start", round_start, 0);
    rst_n = 1'b1;
    m_reset();
    rs_base = rs_total;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (grant_vld !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic rand_inputs();
    logic [7:0]  q;
    logic [31:0] w;
    logic [7:0]  nz;
    bit ok;
    w = weights;
    if ($urandom_range(0, 2) == 0)
      for (int i = 0; i < NQ; i++)
        w[i*WB +: WB] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    for (int i = 0; i < NQ; i++) nz[i] = (w[i*WB +: WB] != 4'd0);
    ok = 1'b0;
    q = '0;
    for (int t = 0; t < 20 && !ok; t++) begin
      q = 8'($urandom);
      ok = STRICT ? (q[7] || ((q[6:0] & nz[6:0]) != '0)) : ((q & nz) != '0);
    end
    if (!ok) begin
      q = 8'h01;
      if (w[3:0] == 4'd0) w[3:0] = 4'd1;
    end
    q_vld = q;
    weights = w;
  endtask

  // mode: 0 leave inputs, 1 randomize inputs, 2 load q_vld=nq, applied while busy
  task automatic serve(input int exp_id, input string nm, input int rdy_dly,
                       input int done_dly, input int mode, input logic [7:0] nq,
                       output int lat);
    logic [2:0] e3;
    e3 = 3'(exp_id);
    wait_grant(lat);
    chk({nm, " grant_vld"}, grant_vld, 1);
    if (grant_vld !== 1'b1) return;
    chk({nm, " grant_id"}, grant_id, exp_id);
    for (int k = 0; k < rdy_dly; k++) begin
      @(negedge clk);
      chk({nm, " held"}, {grant_vld, busy, grant_id}, {1'b1, 1'b0, e3});
    end
    grant_rdy = 1'b1;
    @(negedge clk);
    grant_rdy = 1'b0;
    chk({nm, " accepted"}, {grant_vld, busy}, 2'b01);
    if (mode == 1) rand_inputs();
    else if (mode == 2) q_vld = nq;
    repeat (done_dly) @(negedge clk);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    chk({nm, " done"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int viol;
    int e;
    logic [39:0] sq;

`ifdef WRR_STRICT_TOP_EN
    vecs[0] = '{q: 8'h7F, w: 32'h11111111, n: 4'd8, seq: 40'h0006543210, rs: 4'd2};
`else
    vecs[0] = '{q: 8'hFF, w: 32'h11111111, n: 4'd9, seq: 40'h0076543210, rs: 4'd2};
`endif
    vecs[1] = '{q: 8'h03, w: 32'h00000013, n: 4'd8, seq: 40'h0010001000, rs: 4'd2};
    vecs[2] = '{q: 8'h0C, w: 32'h00001200, n: 4'd6, seq: 40'h0000322322, rs: 4'd2};
    vecs[3] = '{q: 8'h22, w: 32'h00200010, n: 4'd6, seq: 40'h0000551551, rs: 4'd2};
    vecs[4] = '{q: 8'h07, w: 32'h00000120, n: 4'd6, seq: 40'h0000211211, rs: 4'd2};

    // table-driven grant sequences
    for (int v = 0; v < 5; v++) begin
      do_reset();
      q_vld = vecs[v].q;
      weights = vecs[v].w;
      sq = vecs[v].seq;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        serve(int'(sq[4*k +: 4]), $sformatf("vec%0d pkt%0d", v, k), 0, 1, 0, 8'h00, lat);
        if (v == 0 && k == 1) chk("vec0 latency with credit", lat, 1);
      end
      chk($sformatf("vec%0d round_start count", v), rs_total - rs_base, vecs[v].rs);
    end

    // stalled offer: sticky, stable, pkt_done ignored, credit spent only on accept
    do_reset();
    weights = 32'h00000100;
    q_vld = 8'h04;
    wait_grant(lat);
    chk("stall latency after reload", lat, 3);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin q_vld = 8'h00; pkt_done = 1'b1; end
      if (k == 2) pkt_done = 1'b0;
      @(negedge clk);
      chk($sformatf("stall cyc%0d", k), {grant_vld, busy, grant_id}, {1'b1, 1'b0, 3'd2});
    end
    grant_rdy = 1'b1;
    @(negedge clk);
    grant_rdy = 1'b0;
    chk("stall accepted", {grant_vld, busy}, 2'b01);
    @(negedge clk);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    q_vld = 8'h04;
    serve(2, "stall regrant", 0, 1, 0, 8'h00, lat);
    chk("stall regrant latency", lat, 3);
    chk("stall round_start count", rs_total - rs_base, 2);

    // weight change mid-round applies from the next reload
    do_reset();
    weights = 32'h22222222;
    q_vld = 8'h03;
    serve(0, "wchg pkt0", 0, 1, 0, 8'h00, lat);
    weights = 32'h11111111;
    serve(0, "wchg pkt1", 0, 1, 0, 8'h00, lat);
    chk("wchg latency with credit", lat, 1);
    serve(1, "wchg pkt2", 0, 1, 0, 8'h00, lat);
    serve(1, "wchg pkt3", 0, 1, 0, 8'h00, lat);
    serve(0, "wchg pkt4", 0, 1, 0, 8'h00, lat);
    serve(1, "wchg pkt5", 0, 1, 0, 8'h00, lat);
    serve(0, "wchg pkt6", 0, 1, 0, 8'h00, lat);
    serve(1, "wchg pkt7", 0, 1, 0, 8'h00, lat);
    chk("wchg round_start count", rs_total - rs_base, 3);

    // asynchronous reset in the middle of a packet
    do_reset();
    weights = 32'h11111111;
    q_vld = 8'h7F;
    serve(0, "abort pkt0", 0, 1, 0, 8'h00, lat);
    serve(1, "abort pkt1", 0, 1, 0, 8'h00, lat);
    serve(2, "abort pkt2", 0, 1, 0, 8'h00, lat);
    wait_grant(lat);
    chk("abort grant_id", grant_id, 3);
    grant_rdy = 1'b1;
    @(negedge clk);
    grant_rdy = 1'b0;
    chk("abort busy before reset", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("abort async clear", {grant_vld, busy, round_start, grant_id}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    rs_base = rs_total;
    serve(0, "abort first after reset", 0, 1, 0, 8'h00, lat);
    chk("abort reload latency", lat, 3);
    chk("abort round_start count", rs_total - rs_base, 1);

    // all requesters weight 0: IDLE/RELOAD cycling, no grant
    do_reset();
    weights = 32'h00000000;
    q_vld = 8'h01;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant_vld !== 1'b0) viol++;
    end
    chk("zero weight grants", viol, 0);
    chk("zero weight round_start count", rs_total - rs_base, 10);

`ifdef WRR_STRICT_TOP_EN
    // strict top queue ahead of WRR, independent of its zero credit
    do_reset();
    weights = 32'h00000002;
    q_vld = 8'h81;
    serve(7, "strict pkt0", 0, 1, 0, 8'h00, lat);
    chk("strict latency no reload", lat, 1);
    serve(7, "strict pkt1", 0, 1, 2, 8'h01, lat);
    serve(0, "strict pkt2", 0, 1, 0, 8'h00, lat);
    serve(0, "strict pkt3", 0, 1, 2, 8'h81, lat);
    serve(7, "strict pkt4", 0, 1, 2, 8'h01, lat);
    serve(0, "strict pkt5", 0, 1, 0, 8'h00, lat);
    chk("strict round_start count", rs_total - rs_base, 2);
`endif

    // randomized run against the model
    do_reset();
    rand_inputs();
    for (int p = 0; p < 150; p++) begin
      e = m_pick();
      serve(e, $sformatf("rand pkt%0d", p), $urandom_range(0, 3), $urandom_range(0, 3),
            1, 8'h00, lat);
      if (e >= 0) m_accept(e);
      chk($sformatf("rand pkt%0d round_start count", p), rs_total - rs_base, m_reloads);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
